// File: rtl/clk_div_multi.sv
// Multi-channel runtime-programmable clock divider.
// Each channel produces a one-cycle tick enable and a near-50% square wave from clk.
// New divisors are staged in a per-channel pending slot and swapped in only at a
// counter wrap (or immediately when the channel is idle), so outputs never glitch.
module clk_div_multi #(
  parameter int unsigned  NCH     = 4,
  parameter int unsigned  WIDTH   = 24,
  parameter int unsigned  DEF_DIV = 12_000_000,
  localparam int unsigned CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   en,
  input  logic             sync,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [WIDTH-1:0] cfg_div,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   clkout,
  output logic [NCH-1:0]   busy
);

  logic [NCH-1:0][WIDTH-1:0] cnt_q, cnt_d;
  logic [NCH-1:0][WIDTH-1:0] div_cur_q, div_cur_d;
  logic [NCH-1:0][WIDTH-1:0] div_pend_q, div_pend_d;
  logic [NCH-1:0]            pend_q, pend_d;
  logic [NCH-1:0]            tick_q, tick_d;
  logic [NCH-1:0]            clkout_q, clkout_d;
  logic [NCH-1:0]            acc;

  // Ready reflects the addressed channel's pending slot; out-of-range channels always accept.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        cfg_ready = !pend_q[i];
      end
    end
  end

  // Per-channel accept strobe; an accept to a channel >= NCH matches nothing and is dropped.
  always_comb begin
    acc = '0;
    for (int i = 0; i < NCH; i++) begin
      acc[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
    end
  end

  // Next-state for counters, divisors and registered outputs.
  always_comb begin
    cnt_d      = cnt_q;
    div_cur_d  = div_cur_q;
    div_pend_d = div_pend_q;
    pend_d     = pend_q;
    tick_d     = '0;
    clkout_d   = clkout_q;
    for (int i = 0; i < NCH; i++) begin
      if (div_cur_q[i] == '0) begin
        // Channel off: park everything low, pick up any staged divisor.
        cnt_d[i]    = '0;
        clkout_d[i] = 1'b0;
        if (pend_q[i]) begin
          div_cur_d[i] = div_pend_q[i];
          pend_d[i]    = 1'b0;
        end
      end else if (sync) begin
        cnt_d[i] = '0;
        if (en[i]) begin
          clkout_d[i] = (cnt_q[i] >= (div_cur_q[i] >> 1));
        end
        if (pend_q[i]) begin
          div_cur_d[i] = div_pend_q[i];
          pend_d[i]    = 1'b0;
        end
      end else if (!en[i]) begin
        // Disabled: hold phase, but a staged divisor can go in right away.
        if (pend_q[i]) begin
          div_cur_d[i] = div_pend_q[i];
          pend_d[i]    = 1'b0;
          cnt_d[i]     = '0;
        end
      end else begin
        tick_d[i]   = (cnt_q[i] == div_cur_q[i] - WIDTH'(1));
        clkout_d[i] = (cnt_q[i] >= (div_cur_q[i] >> 1));
        if (cnt_q[i] == div_cur_q[i] - WIDTH'(1)) begin
          cnt_d[i] = '0;
          if (pend_q[i]) begin
            div_cur_d[i] = div_pend_q[i];
            pend_d[i]    = 1'b0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + WIDTH'(1);
        end
      end
      // Accept only happens with pend_q clear, so it never collides with an apply above.
      if (acc[i]) begin
        div_pend_d[i] = cfg_div;
        pend_d[i]     = 1'b1;
      end
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      div_pend_q <= '0;
      pend_q     <= '0;
      tick_q     <= '0;
      clkout_q   <= '0;
      for (int i = 0; i < NCH; i++) begin
        div_cur_q[i] <= WIDTH'(DEF_DIV);
      end
    end else begin
      cnt_q      <= cnt_d;
      div_cur_q  <= div_cur_d;
      div_pend_q <= div_pend_d;
      pend_q     <= pend_d;
      tick_q     <= tick_d;
      clkout_q   <= clkout_d;
    end
  end

  assign tick   = tick_q;
  assign clkout = clkout_q;
  assign busy   = pend_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: stimulus pushes hand-computed expectations tagged
// with the cycle they apply to; a negedge monitor pops and compares them.
module tb_clk_div_multi;

  localparam int unsigned NCH     = 3;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned DEF_DIV = 4;
  localparam int unsigned CH_W    = 2;

  localparam int KTick  = 0;
  localparam int KClk   = 1;
  localparam int KBusy  = 2;
  localparam int KReady = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   en;
  logic             sync;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [WIDTH-1:0] cfg_div;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   clkout;
  logic [NCH-1:0]   busy;

  typedef struct {
    int             cyc;
    int             kind;
    logic [NCH-1:0] mask;
    logic [NCH-1:0] val;
    string          name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  clk_div_multi #(
    .NCH     (NCH),
    .WIDTH   (WIDTH),
    .DEF_DIV (DEF_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sync      (sync),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .tick      (tick),
    .clkout    (clkout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation due at or before this cycle.
  always @(negedge clk) begin
    exp_t           e;
    logic [NCH-1:0] act;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      act = '0;
      case (e.kind)
        KTick:   act = tick;
        KClk:    act = clkout;
        KBusy:   act = busy;
        default: act[0] = cfg_ready;
      endcase
      n_checks++;
      if ((act & e.mask) !== (e.val & e.mask)) begin
        n_fail++;
        $display("FAIL %s cyc=%0d got=%b want=%b mask=%b", e.name, cyc, act, e.val, e.mask);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int dcyc, input int kind, input logic [NCH-1:0] mask,
                          input logic [NCH-1:0] val, input string name);
    exp_t e;
    e.cyc  = cyc + dcyc;
    e.kind = kind;
    e.mask = mask;
    e.val  = val;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic cfg(input logic [CH_W-1:0] ch, input logic [WIDTH-1:0] dv);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_div   = dv;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NCH-1:0] tv;
    logic [NCH-1:0] cv;
    rst = 1'b1; en = '0; sync = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
    step();
    n_checks++;
    if (tick !== 3'b000 || clkout !== 3'b000 || busy !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_direct cyc=%0d got=%b%b%b want=000000000", cyc, tick, clkout, busy);
    end
    en = '1;
    push_exp(1, KTick, 3'b111, 3'b000, "rst_tick");
    push_exp(1, KClk,  3'b111, 3'b000, "rst_clkout");
    push_exp(1, KBusy, 3'b111, 3'b000, "rst_busy");
    step();
    rst = 1'b0;

    // Default divisor 4 on all channels.
    for (int k = 1; k <= 12; k++) begin
      cv = (((k - 1) % 4) >= 2) ? 3'b111 : 3'b000;
      tv = (((k - 1) % 4) == 3) ? 3'b111 : 3'b000;
      push_exp(1, KClk,  3'b111, cv, "div4_clkout");
      push_exp(1, KTick, 3'b111, tv, "div4_tick");
      push_exp(1, KBusy, 3'b111, 3'b000, "div4_busy");
      step();
    end

    // Odd divisor loaded into a disabled channel; clkout holds its last value (1).
    en = 3'b110;
    cfg(2'd0, 8'd5);
    push_exp(0, KReady, 3'b001, 3'b001, "odd_ready");
    push_exp(1, KBusy,  3'b001, 3'b001, "odd_busy_set");
    push_exp(1, KClk,   3'b001, 3'b001, "dis_clk_hold");
    push_exp(1, KTick,  3'b001, 3'b000, "dis_tick");
    step();
    cfg_valid = 1'b0;
    push_exp(1, KBusy, 3'b001, 3'b000, "odd_busy_clr");
    push_exp(1, KClk,  3'b001, 3'b001, "dis_clk_hold2");
    step();
    en = 3'b111;
    for (int k = 1; k <= 10; k++) begin
      cv = '0; tv = '0;
      cv[0] = (((k - 1) % 5) >= 2);
      tv[0] = (((k - 1) % 5) == 4);
      push_exp(1, KClk,  3'b001, cv, "div5_clkout");
      push_exp(1, KTick, 3'b001, tv, "div5_tick");
      step();
    end

    // Mid-period reload: ch1 at div 8, reload to 3 at cnt=2, second cfg stalled.
    en = 3'b101;
    cfg(2'd1, 8'd8);
    step();
    cfg_valid = 1'b0;
    step();
    en = 3'b111;
    for (int k = 1; k <= 17; k++) begin
      if (k == 3) begin
        cfg(2'd1, 8'd3);
        push_exp(0, KReady, 3'b001, 3'b001, "reload_ready");
      end else if (k == 4 || k == 5) begin
        cfg(2'd1, 8'd7);
        push_exp(0, KReady, 3'b001, 3'b000, "reload_stall");
      end else begin
        cfg_valid = 1'b0;
      end
      tv = '0; cv = '0;
      tv[1] = (k == 8) || (k > 8 && ((k - 8) % 3) == 0);
      cv[1] = (k <= 8) ? (k >= 5) : (((k - 9) % 3) >= 1);
      push_exp(1, KTick, 3'b010, tv, "reload_tick");
      push_exp(1, KClk,  3'b010, cv, "reload_clkout");
      push_exp(1, KBusy, 3'b010, (k >= 3 && k <= 7) ? 3'b010 : 3'b000, "reload_busy");
      step();
    end

    // sync with ch0 div 4, ch1 div 6, ch2 div 4; cfg in the sync cycle stays pending.
    en = 3'b100;
    cfg(2'd0, 8'd4);
    step();
    cfg(2'd1, 8'd6);
    step();
    cfg_valid = 1'b0;
    step();
    en = 3'b111;
    step(); step(); step();
    for (int k = 0; k <= 12; k++) begin
      if (k == 0) begin
        sync = 1'b1;
        cfg(2'd0, 8'd2);
        push_exp(0, KReady, 3'b001, 3'b001, "sync_cfg_ready");
      end else begin
        sync = 1'b0;
        cfg_valid = 1'b0;
      end
      tv = '0;
      tv[0] = (k >= 4) && ((k % 2) == 0);
      tv[1] = (k == 6) || (k == 12);
      tv[2] = (k > 0) && ((k % 4) == 0);
      push_exp(1, KTick, 3'b111, tv, "sync_tick");
      push_exp(1, KBusy, 3'b111, (k <= 3) ? 3'b001 : 3'b000, "sync_busy");
      if (k >= 1) begin
        cv = '0;
        cv[1] = (((k - 1) % 6) >= 3);
        push_exp(1, KClk, 3'b010, cv, "sync_clkout");
      end
      step();
    end

    // div 0 on ch2, div 1 on ch0, out-of-range channel consumed harmlessly.
    en = 3'b010;
    cfg(2'd2, 8'd0);
    push_exp(0, KReady, 3'b001, 3'b001, "div0_ready");
    step();
    cfg(2'd0, 8'd1);
    step();
    cfg(2'd3, 8'd9);
    #1;
    n_checks++;
    if (cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_ready_direct cyc=%0d got=%b want=1", cyc, cfg_ready);
    end
    push_exp(0, KReady, 3'b001, 3'b001, "oor_ready");
    push_exp(1, KBusy,  3'b111, 3'b000, "oor_busy");
    step();
    cfg_valid = 1'b0;
    en = 3'b111;
    for (int k = 1; k <= 6; k++) begin
      push_exp(1, KTick, 3'b101, 3'b001, "div01_tick");
      push_exp(1, KClk,  3'b101, 3'b001, "div01_clkout");
      push_exp(1, KBusy, 3'b111, 3'b000, "div01_busy");
      step();
    end

    // Reset mid-operation with a pending divisor.
    cfg(2'd1, 8'd9);
    push_exp(0, KReady, 3'b001, 3'b001, "pre_rst_ready");
    push_exp(1, KBusy,  3'b010, 3'b010, "pre_rst_busy");
    step();
    cfg_valid = 1'b0;
    rst = 1'b1;
    push_exp(1, KTick, 3'b111, 3'b000, "rst2_tick");
    push_exp(1, KClk,  3'b111, 3'b000, "rst2_clkout");
    push_exp(1, KBusy, 3'b111, 3'b000, "rst2_busy");
    step();
    n_checks++;
    if (tick !== 3'b000 || clkout !== 3'b000 || busy !== 3'b000) begin
      n_fail++;
      $display("FAIL rst2_direct cyc=%0d got=%b%b%b want=000000000", cyc, tick, clkout, busy);
    end
    n_checks++;
    if (busy[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL rst2_pend_direct cyc=%0d got=%b want=0", cyc, busy[1]);
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cv = (((k - 1) % 4) >= 2) ? 3'b111 : 3'b000;
      tv = (((k - 1) % 4) == 3) ? 3'b111 : 3'b000;
      push_exp(1, KClk,  3'b111, cv, "post_rst_clkout");
      push_exp(1, KTick, 3'b111, tv, "post_rst_tick");
      push_exp(1, KBusy, 3'b111, 3'b000, "post_rst_busy");
      step();
    end

    step();
    step();
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s unchecked got=none want=%b", e.name, e.val);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
